// File: rtl/accel_cfg_bank.sv
// accel_cfg_bank: runtime configuration bank for NR_CH accelerator channels.
// Software fills a per-channel shadow register set, then commits it.
// A per-channel FSM copies shadow to active only while the channel is idle.
// Optional build macro ACCEL_CFG_LOCK_EN adds sticky per-channel lock ports.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | no commit outstanding, shadow writes allowed
//   ST_PEND  | commit seen, waiting for ch_idle_i
//   ST_APPLY | copying shadow to active on the edge that leaves this state
module accel_cfg_bank #(
  parameter int unsigned NR_CH   = 4,
  parameter int unsigned NR_REGS = 8,
  parameter int unsigned DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  localparam int unsigned CH_W  = (NR_CH > 1) ? $clog2(NR_CH) : 1,
  localparam int unsigned IDX_W = $clog2(NR_REGS)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              wr_valid_i,
  output logic                              wr_ready_o,
  input  logic [CH_W-1:0]                   wr_ch_i,
  input  logic [IDX_W-1:0]                  wr_idx_i,
  input  logic [DATA_W-1:0]                 wr_data_i,
  input  logic [NR_CH-1:0]                  commit_i,
  input  logic [NR_CH-1:0]                  ch_idle_i,
  output logic [NR_CH-1:0]                  apply_o,
  output logic [NR_CH-1:0]                  pending_o,
  input  logic [CH_W-1:0]                   rd_ch_i,
  input  logic [IDX_W-1:0]                  rd_idx_i,
  input  logic                              rd_shadow_i,
  output logic [DATA_W-1:0]                 rd_data_o,
`ifdef ACCEL_CFG_LOCK_EN
  input  logic [NR_CH-1:0]                  lock_i,
  output logic [NR_CH-1:0]                  locked_o,
`endif
  output logic [NR_CH*NR_REGS*DATA_W-1:0]   cfg_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_APPLY} state_e;

  state_e                  state_q [NR_CH];
  state_e                  state_d [NR_CH];
  logic [DATA_W-1:0]       shadow_q [NR_CH][NR_REGS];
  logic [DATA_W-1:0]       active_q [NR_CH][NR_REGS];
  logic [NR_CH-1:0]        apply_q;
  logic [NR_CH-1:0]        lock_mask;
  logic                    wr_ch_ok;
  logic                    rd_ch_ok;
  logic                    wr_en;

`ifdef ACCEL_CFG_LOCK_EN
  logic [NR_CH-1:0]        locked_q;

  // Sticky lock: set by a lock_i pulse, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) locked_q <= '0;
    else       locked_q <= locked_q | lock_i;
  end

  assign lock_mask = locked_q;
  assign locked_o  = locked_q;
`else
  assign lock_mask = '0;
`endif

  assign wr_ch_ok = 32'(wr_ch_i) < NR_CH;
  assign rd_ch_ok = 32'(rd_ch_i) < NR_CH;

  // Out-of-range and locked channels always look ready so the writer never stalls on a dropped write.
  always_comb begin
    wr_ready_o = 1'b1;
    wr_en      = 1'b0;
    if (wr_ch_ok) begin
      wr_ready_o = lock_mask[wr_ch_i] || (state_q[wr_ch_i] == ST_IDLE);
      wr_en      = wr_valid_i && !lock_mask[wr_ch_i] && (state_q[wr_ch_i] == ST_IDLE);
    end
  end

  // Per-channel next-state logic; commits are only taken in IDLE, so repeats are ignored.
  always_comb begin
    for (int c = 0; c < NR_CH; c++) begin
      state_d[c] = state_q[c];
      case (state_q[c])
        ST_IDLE:  if (commit_i[c] && !lock_mask[c]) state_d[c] = ST_PEND;
        ST_PEND:  if (ch_idle_i[c]) state_d[c] = ST_APPLY;
        ST_APPLY: state_d[c] = ST_IDLE;
        default:  state_d[c] = ST_IDLE;
      endcase
    end
  end

  // State registers and the one-cycle apply pulse following the copy edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NR_CH; c++) state_q[c] <= ST_IDLE;
      apply_q <= '0;
    end else begin
      for (int c = 0; c < NR_CH; c++) begin
        state_q[c] <= state_d[c];
        apply_q[c] <= (state_q[c] == ST_APPLY);
      end
    end
  end

  // Shadow registers take accepted writes on the accepting edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NR_CH; c++)
        for (int r = 0; r < NR_REGS; r++) shadow_q[c][r] <= RST_VAL;
    end else if (wr_en) begin
      shadow_q[wr_ch_i][wr_idx_i] <= wr_data_i;
    end
  end

  // Active registers copy the whole shadow set on the edge leaving APPLY.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NR_CH; c++)
        for (int r = 0; r < NR_REGS; r++) active_q[c][r] <= RST_VAL;
    end else begin
      for (int c = 0; c < NR_CH; c++)
        if (state_q[c] == ST_APPLY) active_q[c] <= shadow_q[c];
    end
  end

  // Readback mux; an out-of-range channel reads as zero.
  always_comb begin
    rd_data_o = '0;
    if (rd_ch_ok) rd_data_o = rd_shadow_i ? shadow_q[rd_ch_i][rd_idx_i]
                                          : active_q[rd_ch_i][rd_idx_i];
  end

  always_comb begin
    for (int c = 0; c < NR_CH; c++) pending_o[c] = (state_q[c] != ST_IDLE);
  end

  assign apply_o = apply_q;

  for (genvar c = 0; c < NR_CH; c++) begin : g_cfg_ch
    for (genvar r = 0; r < NR_REGS; r++) begin : g_cfg_reg
      assign cfg_o[(c*NR_REGS+r)*DATA_W +: DATA_W] = active_q[c][r];
    end
  end

endmodule

// File: tb/tb_accel_cfg_bank.sv
// Directed testbench for accel_cfg_bank (NR_CH=4, NR_REGS=8, DATA_W=32).
module tb_accel_cfg_bank;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic [1:0]    wr_ch_i;
  logic [2:0]    wr_idx_i;
  logic [31:0]   wr_data_i;
  logic [3:0]    commit_i;
  logic [3:0]    ch_idle_i;
  logic [3:0]    apply_o;
  logic [3:0]    pending_o;
  logic [1:0]    rd_ch_i;
  logic [2:0]    rd_idx_i;
  logic          rd_shadow_i;
  logic [31:0]   rd_data_o;
  logic [1023:0] cfg_o;
`ifdef ACCEL_CFG_LOCK_EN
  logic [3:0]    lock_i;
  logic [3:0]    locked_o;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  accel_cfg_bank dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .wr_ch_i     (wr_ch_i),
    .wr_idx_i    (wr_idx_i),
    .wr_data_i   (wr_data_i),
    .commit_i    (commit_i),
    .ch_idle_i   (ch_idle_i),
    .apply_o     (apply_o),
    .pending_o   (pending_o),
    .rd_ch_i     (rd_ch_i),
    .rd_idx_i    (rd_idx_i),
    .rd_shadow_i (rd_shadow_i),
    .rd_data_o   (rd_data_o),
`ifdef ACCEL_CFG_LOCK_EN
    .lock_i      (lock_i),
    .locked_o    (locked_o),
`endif
    .cfg_o       (cfg_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic read_reg(input logic [1:0] ch, input logic [2:0] idx,
                          input logic shadow, output logic [31:0] val);
    rd_ch_i     = ch;
    rd_idx_i    = idx;
    rd_shadow_i = shadow;
    #1;
    val = rd_data_o;
  endtask

  function automatic logic [31:0] cfg_word(input int ch, input int idx);
    return cfg_o[(ch*8+idx)*32 +: 32];
  endfunction

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    tests_run++;
    if (cfg_o !== '0) begin
      tests_failed++; $display("FAIL reset_cfg got %h expected 0", cfg_o[127:0]);
    end
    tests_run++;
    if (apply_o !== 4'b0 || pending_o !== 4'b0 || wr_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_flags apply=%b pending=%b ready=%b expected 0000 0000 1",
               apply_o, pending_o, wr_ready_o);
    end
  endtask

  task automatic test_basic();
    wr_valid_i = 1'b1; wr_ch_i = 2'd1; wr_idx_i = 3'd3; wr_data_i = 32'hA5A5_0001;
    tick();
    wr_valid_i = 1'b0; commit_i = 4'b0010;
    tick();                           // commit edge -> PEND
    commit_i = 4'b0;
    tests_run++;
    if (pending_o !== 4'b0010 || apply_o !== 4'b0) begin
      tests_failed++; $display("FAIL basic_pend pending=%b apply=%b expected 0010 0000", pending_o, apply_o);
    end
    tick();                           // -> APPLY
    tests_run++;
    if (apply_o !== 4'b0 || cfg_word(1, 3) !== 32'h0) begin
      tests_failed++; $display("FAIL basic_early apply=%b cfg=%h expected 0000 0", apply_o, cfg_word(1, 3));
    end
    tick();                           // copy edge
    tests_run++;
    if (apply_o !== 4'b0010 || pending_o !== 4'b0) begin
      tests_failed++; $display("FAIL basic_apply apply=%b pending=%b expected 0010 0000", apply_o, pending_o);
    end
    tests_run++;
    if (cfg_word(1, 3) !== 32'hA5A5_0001) begin
      tests_failed++; $display("FAIL basic_cfg got %h expected a5a50001", cfg_word(1, 3));
    end
    tick();
    tests_run++;
    if (apply_o !== 4'b0) begin
      tests_failed++; $display("FAIL basic_pulse_width apply=%b expected 0000", apply_o);
    end
  endtask

  task automatic test_busy();
    logic [31:0] v;
    int stalls;
    ch_idle_i = 4'b1011;
    commit_i  = 4'b0100;
    tick();
    commit_i  = 4'b0;
    wr_valid_i = 1'b1; wr_ch_i = 2'd2; wr_idx_i = 3'd1; wr_data_i = 32'h0000_0077;
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (wr_ready_o === 1'b0 && pending_o[2] === 1'b1) stalls++;
      commit_i = (i == 4) ? 4'b0100 : 4'b0;   // repeat commit while pending is ignored
      tick();
    end
    commit_i = 4'b0;
    tests_run++;
    if (stalls != 10) begin
      tests_failed++; $display("FAIL busy_stall stalled %0d cycles expected 10", stalls);
    end
    read_reg(2'd2, 3'd1, 1'b1, v);
    tests_run++;
    if (v !== 32'h0) begin
      tests_failed++; $display("FAIL busy_shadow_held got %h expected 0", v);
    end
    ch_idle_i = 4'b1111;
    tick();                           // -> APPLY
    tests_run++;
    if (wr_ready_o !== 1'b0) begin
      tests_failed++; $display("FAIL busy_apply_ready got %b expected 0", wr_ready_o);
    end
    tick();                           // -> IDLE
    tests_run++;
    if (wr_ready_o !== 1'b1 || apply_o !== 4'b0100) begin
      tests_failed++; $display("FAIL busy_release ready=%b apply=%b expected 1 0100", wr_ready_o, apply_o);
    end
    tick();                           // held write lands now
    wr_valid_i = 1'b0;
    read_reg(2'd2, 3'd1, 1'b1, v);
    tests_run++;
    if (v !== 32'h77 || cfg_word(2, 1) !== 32'h0 || pending_o !== 4'b0 || apply_o !== 4'b0) begin
      tests_failed++;
      $display("FAIL busy_after shadow=%h active=%h pending=%b apply=%b expected 77 0 0000 0000",
               v, cfg_word(2, 1), pending_o, apply_o);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] v;
    wr_valid_i = 1'b1; wr_ch_i = 2'd0; wr_idx_i = 3'd0; wr_data_i = 32'h55;
    commit_i = 4'b0001;
    tick();
    wr_valid_i = 1'b0; commit_i = 4'b0;
    tick();
    tick();
    read_reg(2'd0, 3'd0, 1'b0, v);
    tests_run++;
    if (apply_o !== 4'b0001 || v !== 32'h55 || cfg_word(0, 0) !== 32'h55) begin
      tests_failed++;
      $display("FAIL same_cycle apply=%b active=%h cfg=%h expected 0001 55 55", apply_o, v, cfg_word(0, 0));
    end
  endtask

  task automatic test_parallel();
    logic [31:0] vs, va;
    for (int c = 0; c < 4; c++) begin
      wr_valid_i = 1'b1; wr_ch_i = 2'(c); wr_idx_i = 3'd7; wr_data_i = 32'h1000 + 32'(c);
      tick();
    end
    wr_valid_i = 1'b0;
    commit_i = 4'b1111;
    tick();
    commit_i = 4'b0;
    tick();
    tick();
    tests_run++;
    if (apply_o !== 4'b1111) begin
      tests_failed++; $display("FAIL parallel_apply got %b expected 1111", apply_o);
    end
    for (int c = 0; c < 4; c++) begin
      read_reg(2'(c), 3'd7, 1'b1, vs);
      read_reg(2'(c), 3'd7, 1'b0, va);
      tests_run++;
      if (vs !== 32'h1000 + 32'(c) || va !== 32'h1000 + 32'(c) || cfg_word(c, 7) !== 32'h1000 + 32'(c)) begin
        tests_failed++;
        $display("FAIL parallel_ch%0d shadow=%h active=%h cfg=%h expected %h", c, vs, va, cfg_word(c, 7),
                 32'h1000 + 32'(c));
      end
    end
    // Earlier values must survive the whole-set copy.
    tests_run++;
    if (cfg_word(1, 3) !== 32'hA5A5_0001 || cfg_word(0, 0) !== 32'h55) begin
      tests_failed++; $display("FAIL parallel_keep ch1r3=%h ch0r0=%h expected a5a50001 55",
                               cfg_word(1, 3), cfg_word(0, 0));
    end
  endtask

  task automatic test_reset_mid_pend();
    logic [31:0] v;
    ch_idle_i = 4'b0111;
    wr_valid_i = 1'b1; wr_ch_i = 2'd3; wr_idx_i = 3'd2; wr_data_i = 32'hDEAD;
    tick();
    wr_valid_i = 1'b0; commit_i = 4'b1000;
    tick();
    commit_i = 4'b0;
    tests_run++;
    if (pending_o !== 4'b1000) begin
      tests_failed++; $display("FAIL midpend_pending got %b expected 1000", pending_o);
    end
    rst_i = 1'b1;
    #1;
    tests_run++;
    if (pending_o !== 4'b0 || cfg_o !== '0) begin
      tests_failed++; $display("FAIL midpend_async pending=%b cfg_low=%h expected 0000 0", pending_o, cfg_o[255:0]);
    end
    tick();
    rst_i = 1'b0;
    ch_idle_i = 4'b1111;
    tick();
    tick();
    read_reg(2'd3, 3'd2, 1'b1, v);
    tests_run++;
    if (v !== 32'h0 || cfg_word(3, 2) !== 32'h0 || apply_o !== 4'b0) begin
      tests_failed++; $display("FAIL midpend_after shadow=%h active=%h apply=%b expected 0 0 0000",
                               v, cfg_word(3, 2), apply_o);
    end
  endtask

`ifdef ACCEL_CFG_LOCK_EN
  task automatic test_lock();
    logic [31:0] v;
    int applies;
    lock_i = 4'b1000;
    tick();
    lock_i = 4'b0;
    wr_valid_i = 1'b1; wr_ch_i = 2'd3; wr_idx_i = 3'd0; wr_data_i = 32'hFF;
    #1;
    tests_run++;
    if (wr_ready_o !== 1'b1 || locked_o !== 4'b1000) begin
      tests_failed++; $display("FAIL lock_ready ready=%b locked=%b expected 1 1000", wr_ready_o, locked_o);
    end
    tick();
    wr_valid_i = 1'b0; commit_i = 4'b1000;
    tick();
    commit_i = 4'b0;
    applies = 0;
    for (int i = 0; i < 3; i++) begin
      if (apply_o[3] !== 1'b0 || pending_o[3] !== 1'b0) applies++;
      tick();
    end
    read_reg(2'd3, 3'd0, 1'b1, v);
    tests_run++;
    if (applies != 0 || v !== 32'h0 || cfg_word(3, 0) !== 32'h0) begin
      tests_failed++; $display("FAIL lock_frozen activity=%0d shadow=%h active=%h expected 0 0 0",
                               applies, v, cfg_word(3, 0));
    end
  endtask
`endif

  initial begin
    rst_i = 1'b1; wr_valid_i = 1'b0; wr_ch_i = '0; wr_idx_i = '0; wr_data_i = '0;
    commit_i = '0; ch_idle_i = 4'b1111; rd_ch_i = '0; rd_idx_i = '0; rd_shadow_i = 1'b0;
`ifdef ACCEL_CFG_LOCK_EN
    lock_i = '0;
`endif
    test_reset();
    test_basic();
    test_busy();
    test_same_cycle();
    test_parallel();
    test_reset_mid_pend();
`ifdef ACCEL_CFG_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
